// File: rtl/prog_counter.sv
// prog_counter: prescaled up/down modulus counter with wrap or saturate limits,
// a terminal-count pulse and a sticky overflow flag.
module prog_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam bit SAT = (SATURATE != 0);

    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, up_nxt, dn_nxt;
    logic             tc_q, tc_d, ovf_q, ovf_d;
    logic             step, up_lim, dn_lim, at_lim;

    always_comb begin
        step      = enable && !load && (pre_cnt_q == PRE_LAST);
        // a count above a lowered max_val counts as at-limit going up
        up_lim    = cnt_q >= max_val;
        dn_lim    = cnt_q == '0;
        at_lim    = up_dn ? up_lim : dn_lim;
        up_nxt    = up_lim ? (SAT ? max_val : '0) : cnt_q + WIDTH'(1);
        dn_nxt    = dn_lim ? (SAT ? '0 : max_val) : cnt_q - WIDTH'(1);
        pre_cnt_d = load ? '0 : !enable ? pre_cnt_q : (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PW'(1);
        cnt_d     = load ? ((load_val > max_val) ? max_val : load_val) : step ? (up_dn ? up_nxt : dn_nxt) : cnt_q;
        tc_d      = step && (SAT ? (!at_lim && cnt_d == (up_dn ? max_val : '0)) : at_lim);
        ovf_d     = (step && at_lim) || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: three counter configurations driven by shared stimulus and
// checked every cycle against an integer reference model.
module tb_prog_counter;
    localparam int N = 3;
    localparam int PS [N] = '{1, 1, 3};
    localparam int SA [N] = '{0, 1, 0};

    typedef struct packed {
        int c;
        int e;
        bit t;
        bit o;
    } mst_t;

    logic       clk = 0, reset = 0, enable = 0, up_dn = 1, load = 0, clr_ovf = 0;
    logic [3:0] load_val = 0, max_val = 9;
    logic [3:0] cnt_o [N];
    logic       tc_o [N];
    logic       ovf_o [N];
    mst_t       m [N];
    int         checks = 0, errors = 0;
    bit         cmp_on = 0;

    always #5 clk = ~clk;

    prog_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
        .cnt(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));
    prog_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(1)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
        .cnt(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));
    prog_counter #(.WIDTH(4), .PRESCALE(3), .SATURATE(0)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
        .cnt(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

    // e counts enabled edges since the last step; a step happens on the p-th
    function automatic mst_t nxt(int p, int s, mst_t q, logic en, logic ud, logic ld, int lv, int mx, logic clr);
        mst_t r;
        bit set;
        r = q;
        r.t = 0;
        set = 0;
        if (ld) begin
            r.c = (lv < mx) ? lv : mx;
            r.e = 0;
        end else if (en) begin
            r.e = q.e + 1;
            if (r.e == p) begin
                r.e = 0;
                if (ud && q.c < mx) begin
                    r.c = q.c + 1;
                    r.t = (s != 0) && r.c == mx;
                end else if (!ud && q.c > 0) begin
                    r.c = q.c - 1;
                    r.t = (s != 0) && r.c == 0;
                end else begin
                    if (s != 0) r.c = ud ? mx : 0;
                    else r.c = ud ? 0 : mx;
                    r.t = (s == 0);
                    set = 1;
                end
            end
        end
        r.o = set || (q.o && !clr);
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) for (int i = 0; i < N; i++) m[i] <= '0;
        else for (int i = 0; i < N; i++)
            m[i] <= nxt(PS[i], SA[i], m[i], enable, up_dn, load, int'(load_val), int'(max_val), clr_ovf);
    end

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic lit(string n, int i, int c, int t, int o);
        chk({n, ".cnt"}, int'(cnt_o[i]), c);
        chk({n, ".tc"}, int'(tc_o[i]), t);
        chk({n, ".ovf"}, int'(ovf_o[i]), o);
        chk({n, ".model_cnt"}, m[i].c, c);
        chk({n, ".model_tc"}, int'(m[i].t), t);
        chk({n, ".model_ovf"}, int'(m[i].o), o);
    endtask

    always @(negedge clk) begin
        if (cmp_on) for (int i = 0; i < N; i++) begin
            chk($sformatf("cyc_cnt%0d", i), int'(cnt_o[i]), m[i].c);
            chk($sformatf("cyc_tc%0d", i), int'(tc_o[i]), int'(m[i].t));
            chk($sformatf("cyc_ovf%0d", i), int'(ovf_o[i]), int'(m[i].o));
        end
    end

    initial begin
        reset = 1;
        repeat (2) @(negedge clk);
        cmp_on = 1;
        lit("reset_a", 0, 0, 0, 0);
        lit("reset_c", 2, 0, 0, 0);
        reset = 0; max_val = 9; up_dn = 1; enable = 1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            lit($sformatf("wrap_up%0d", k), 0, k, 0, 0);
        end
        @(negedge clk); lit("wrap_to0", 0, 0, 1, 1);
        @(negedge clk); lit("after_wrap", 0, 1, 0, 1);
        load_val = 2; load = 1; up_dn = 0;
        @(negedge clk); lit("load2", 0, 2, 0, 1);
        load = 0;
        @(negedge clk); lit("down1", 0, 1, 0, 1);
        @(negedge clk); lit("down0", 0, 0, 0, 1);
        @(negedge clk); lit("down_wrap9", 0, 9, 1, 1);
        up_dn = 1;
        @(negedge clk); lit("dir_up_wrap", 0, 0, 1, 1);
        load_val = 3; max_val = 5; load = 1; clr_ovf = 1;
        @(negedge clk); lit("sat_load3", 1, 3, 0, 0);
        load = 0; clr_ovf = 0;
        @(negedge clk); lit("sat4", 1, 4, 0, 0);
        @(negedge clk); lit("sat5", 1, 5, 1, 0);
        @(negedge clk); lit("sat_block1", 1, 5, 0, 1);
        @(negedge clk); lit("sat_block2", 1, 5, 0, 1);
        enable = 0; clr_ovf = 1;
        @(negedge clk); lit("sat_clr", 1, 5, 0, 0);
        clr_ovf = 0; reset = 1;
        @(negedge clk);
        reset = 0; max_val = 9; up_dn = 1; enable = 1;
        @(negedge clk); lit("pre_e1", 2, 0, 0, 0);
        @(negedge clk); lit("pre_e2", 2, 0, 0, 0);
        @(negedge clk); lit("pre_e3", 2, 1, 0, 0);
        @(negedge clk); lit("pre_e4", 2, 1, 0, 0);
        enable = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lit($sformatf("pre_hold%0d", k), 2, 1, 0, 0);
        end
        enable = 1;
        @(negedge clk); lit("pre_e5", 2, 1, 0, 0);
        @(negedge clk); lit("pre_e6", 2, 2, 0, 0);
        load_val = 12; load = 1;
        @(negedge clk); lit("clamp_a", 0, 9, 0, 0); lit("clamp_c", 2, 9, 0, 0);
        load = 0;
        @(negedge clk); lit("ld_a1", 0, 0, 1, 1); lit("ld_c1", 2, 9, 0, 0);
        @(negedge clk); lit("ld_a2", 0, 1, 0, 1); lit("ld_c2", 2, 9, 0, 0);
        @(negedge clk); lit("ld_a3", 0, 2, 0, 1); lit("ld_c3", 2, 0, 1, 1);
        @(posedge clk); #1;
        lit("pre_async_a", 0, 3, 0, 1);
        #1 reset = 1;
        #1 lit("async_a", 0, 0, 0, 0); lit("async_c", 2, 0, 0, 0);
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 99) < 80);
            load     = ($urandom_range(0, 99) < 4);
            clr_ovf  = ($urandom_range(0, 99) < 5);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 10) up_dn = ~up_dn;
            if ($urandom_range(0, 99) < 4) max_val = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
